// File: rtl/ibex_tlul_mux_pkg.sv
// ibex_tlul_mux_pkg: host indices and widths shared by the Ibex TL-UL host mux.
package ibex_tlul_mux_pkg;
    import tlul_pkg::*;

    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_idx_e;

    // The a_source / d_source MSB carries the host index on the merged port.
    localparam int SrcHostBit = TL_AIW - 1;
    localparam int OutstCntW  = 8;

endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL channel types used across the Ibex SoC.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/ibex_tlul_rr_arb2.sv
// ibex_tlul_rr_arb2: two-way arbiter. Round-robin or fixed priority (host 1
// wins), with a lock that freezes the choice while a request is stalled.
module ibex_tlul_rr_arb2
    import ibex_tlul_mux_pkg::*;
#(
    parameter bit RoundRobin = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       hold_i,
    input  logic       ack_i,
    output logic       sel_o
);

    logic arb_last_q, lock_q, sel_q;

    // Pick a winner; a locked choice or an idle cycle keeps the previous one.
    always_comb begin
        sel_o = sel_q;
        if (!lock_q) begin
            case (req_i)
                2'b01:   sel_o = HostInstr;
                2'b10:   sel_o = HostData;
                2'b11:   sel_o = RoundRobin ? ~arb_last_q : HostData;
                default: sel_o = sel_q;
            endcase
        end
    end

    // Arbiter state: last winner, lock while stalled, current choice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_last_q <= 1'b1;
            lock_q     <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            sel_q  <= sel_o;
            lock_q <= hold_i;
            if (ack_i) begin
                arb_last_q <= sel_o;
            end
        end
    end

endmodule

// File: rtl/ibex_tlul_host_mux.sv
// ibex_tlul_host_mux: merges the Ibex instruction (host 0) and data (host 1)
// TL-UL ports onto one device port. The host index rides in the a_source MSB
// and steers D-channel responses back. Per-host outstanding counters gate
// eligibility and catch orphan responses.
// Optional: define IBEX_TLUL_HOST_MUX_STATS_EN for grant/stall counters.
module ibex_tlul_host_mux
    import tlul_pkg::*;
    import ibex_tlul_mux_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 8,
    parameter bit          RoundRobin     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  tl_h2d_t     host0_tl_i,
    output tl_d2h_t     host0_tl_o,
    input  tl_h2d_t     host1_tl_i,
    output tl_d2h_t     host1_tl_o,
    output tl_h2d_t     dev_tl_o,
    input  tl_d2h_t     dev_tl_i,
`ifdef IBEX_TLUL_HOST_MUX_STATS_EN
    output logic [31:0] grant_cnt0_o,
    output logic [31:0] grant_cnt1_o,
    output logic [31:0] stall_cnt_o,
`endif
    output logic        err_o
);

    localparam logic [OutstCntW-1:0] CntMax = OutstCntW'(MaxOutstanding);

    logic                      sel, dev_a_valid, a_hs, d_hs, d_host;
    logic [1:0]                host_valid, src_bad, eligible, inc, dec;
    logic [1:0][OutstCntW-1:0] cnt_q, cnt_d;
    logic                      err_q, err_d;
    tl_h2d_t                   sel_req;

    assign host_valid  = {host1_tl_i.a_valid, host0_tl_i.a_valid};
    assign src_bad     = {host1_tl_i.a_source[SrcHostBit], host0_tl_i.a_source[SrcHostBit]};
    assign eligible[0] = host_valid[0] && (cnt_q[0] < CntMax);
    assign eligible[1] = host_valid[1] && (cnt_q[1] < CntMax);

    assign sel_req     = sel ? host1_tl_i : host0_tl_i;
    assign dev_a_valid = eligible[sel];
    assign a_hs        = dev_a_valid && dev_tl_i.a_ready;
    assign d_host      = dev_tl_i.d_source[SrcHostBit];
    assign d_hs        = dev_tl_i.d_valid && (d_host ? host1_tl_i.d_ready : host0_tl_i.d_ready);
    assign inc         = {a_hs && sel, a_hs && !sel};
    assign dec         = {d_hs && d_host, d_hs && !d_host};

    ibex_tlul_rr_arb2 #(
        .RoundRobin(RoundRobin)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (eligible),
        .hold_i (dev_a_valid && !dev_tl_i.a_ready),
        .ack_i  (a_hs),
        .sel_o  (sel)
    );

    // Merged A channel from the selected host, host index stamped into the source MSB.
    always_comb begin
        dev_tl_o          = sel_req;
        dev_tl_o.a_valid  = dev_a_valid;
        dev_tl_o.a_source = {sel, sel_req.a_source[SrcHostBit-1:0]};
        dev_tl_o.d_ready  = d_host ? host1_tl_i.d_ready : host0_tl_i.d_ready;
    end

    // D channel routed by source MSB; a_ready only to the selected, eligible host.
    always_comb begin
        host0_tl_o                      = dev_tl_i;
        host0_tl_o.d_source[SrcHostBit] = 1'b0;
        host0_tl_o.d_valid              = dev_tl_i.d_valid && !d_host;
        host0_tl_o.a_ready              = !sel && eligible[0] && dev_tl_i.a_ready;
        host1_tl_o                      = dev_tl_i;
        host1_tl_o.d_source[SrcHostBit] = 1'b0;
        host1_tl_o.d_valid              = dev_tl_i.d_valid && d_host;
        host1_tl_o.a_ready              = sel && eligible[1] && dev_tl_i.a_ready;
    end

    // Outstanding counter next-state; an orphan or a set source MSB raises the error.
    always_comb begin
        err_d = err_q | (|(host_valid & src_bad));
        for (int h = 0; h < 2; h++) begin
            cnt_d[h] = cnt_q[h];
            if (inc[h] && !dec[h]) begin
                cnt_d[h] = cnt_q[h] + 1'b1;
            end else if (dec[h] && !inc[h]) begin
                if (cnt_q[h] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[h] = cnt_q[h] - 1'b1;
                end
            end
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef IBEX_TLUL_HOST_MUX_STATS_EN
    logic [31:0] grant_cnt0_q, grant_cnt1_q, stall_cnt_q;

    // Grant counters wrap; the stall counter saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (inc[0]) grant_cnt0_q <= grant_cnt0_q + 32'd1;
            if (inc[1]) grant_cnt1_q <= grant_cnt1_q + 32'd1;
            if (eligible[~sel] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign grant_cnt0_o = grant_cnt0_q;
    assign grant_cnt1_o = grant_cnt1_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
